// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the rr_stream_mux slice: arbitration mode encodings
// and the rotating-priority search used by rr_pick.
package rr_stream_mux_pkg;

   // Arbitration mode encodings driven on sel_mode.
   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // Widest channel count the rotate search is unrolled for.
   localparam int MAX_CH = 64;

   // Returns the first index with valid set, searching ptr, ptr+1, ...
   // wrapping modulo n_ch; returns -1 when nothing is valid.
   // The wrap is done by a conditional subtract rather than a modulo so the
   // unrolled search stays a plain adder/compare chain.
   function automatic int rotate_pick(input logic [MAX_CH-1:0] valid,
                                      input int               n_ch,
                                      input int               ptr);
      int result;
      int idx;
      result = -1;
      idx    = 0;
      for (int k = 0; k < MAX_CH; k++) begin
         if ((k < n_ch) && (result < 0)) begin
            idx = ptr + k;
            if (idx >= n_ch) begin
               idx = idx - n_ch;
            end
            if (valid[idx[5:0]]) begin
               result = idx;
            end
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_stream_mux_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
// Picks the first valid channel at or after ptr, wrapping modulo N_CH.
module rr_pick
   import rr_stream_mux_pkg::*;
#(
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  in_valid,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] grant,
   output logic             grant_valid
);

   logic [MAX_CH-1:0] valid_ext;
   int                pick;

   // Zero-extend the request vector and run the rotating search.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      valid_ext              = '0;
      valid_ext[N_CH-1:0]    = in_valid;
      pick                   = rotate_pick(valid_ext, N_CH, int'(ptr));
      grant_valid            = (pick >= 0);
      grant                  = pick[SEL_W-1:0];
   end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel, W-bit valid/ready stream multiplexer with a
// registered output stage. Channel choice is round-robin (sel_mode=0) or
// fixed by sel (sel_mode=1). One beat per cycle at full throughput.
// Optional feature macro: RR_STREAM_MUX_LOCK_EN adds in_last/out_last and
// holds the grant on one channel until that channel's packet ends.
module rr_stream_mux
   import rr_stream_mux_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int W     = 8,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sel_mode,
   input  logic [SEL_W-1:0]    sel,
   input  logic [N_CH*W-1:0]   in_data,
   input  logic [N_CH-1:0]     in_valid,
   output logic [N_CH-1:0]     in_ready,
`ifdef RR_STREAM_MUX_LOCK_EN
   input  logic [N_CH-1:0]     in_last,
   output logic                out_last,
`endif
   output logic [W-1:0]        out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SEL_W-1:0]    out_ch
);

   // Channel-indexed vectors are padded to a power of two so any sel value
   // indexes a defined bit; the padding reads as "not valid".
   localparam int N_PAD = 1 << SEL_W;

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] ptr_next;
   logic [SEL_W-1:0] rr_grant;
   logic             rr_grant_valid;
   logic [SEL_W-1:0] grant;
   logic             grant_valid;
   logic             slot_free;
   logic             load;
   logic             advance_ptr;
   logic [N_PAD-1:0] valid_pad;
   logic [W-1:0]     chan_data [N_PAD];

`ifdef RR_STREAM_MUX_LOCK_EN
   logic             lock_q;
   logic [SEL_W-1:0] lock_ch;
   logic [N_PAD-1:0] last_pad;
`endif

   // Round-robin candidate, evaluated every cycle from the current pointer.
   rr_pick #(
      .N_CH        (N_CH)
   ) u_pick (
      .in_valid    (in_valid),
      .ptr         (ptr),
      .grant       (rr_grant),
      .grant_valid (rr_grant_valid)
   );

   // Unpack the flat input bus into per-channel words, padding unused slots.
   always_comb begin
      valid_pad = N_PAD'(in_valid);
      chan_data = '{default: '0};
      for (int i = 0; i < N_CH; i++) begin
         chan_data[i] = in_data[i*W +: W];
      end
   end

`ifdef RR_STREAM_MUX_LOCK_EN
   // Pad in_last the same way as in_valid for safe indexing by grant.
   always_comb begin
      last_pad = N_PAD'(in_last);
   end
`endif

   // Grant selection: round-robin or fixed select, overridden by an open packet.
   always_comb begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
      if (sel_mode == MODE_FIXED) begin
         // sel beyond N_CH-1 lands on a zero pad bit, so nothing is granted.
         grant       = sel;
         grant_valid = valid_pad[sel];
      end
`ifdef RR_STREAM_MUX_LOCK_EN
      if (lock_q) begin
         grant       = lock_ch;
         grant_valid = valid_pad[lock_ch];
      end
`endif
   end

   // Handshake: the output slot can take a beat when empty or being drained.
   always_comb begin
      slot_free = !out_valid || out_ready;
      load      = rst_n && slot_free && grant_valid;
      in_ready  = '0;
      for (int i = 0; i < N_CH; i++) begin
         in_ready[i] = load && (grant == SEL_W'(i));
      end
   end

   // Pointer moves past the granted channel, wrapping N_CH-1 back to 0.
   // It only moves for round-robin grants or while finishing a locked packet.
   always_comb begin
      ptr_next    = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + 1'b1;
      advance_ptr = (sel_mode == MODE_RR);
`ifdef RR_STREAM_MUX_LOCK_EN
      advance_ptr = advance_ptr || lock_q;
`endif
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk) begin
      // NOTE: all sequential state is written with non-blocking assignments so
      // every register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         // NOTE: the data/channel registers are reset too, because their zero
         // value after reset is visible to the consumer.
         ptr       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else begin
         if (load) begin
            out_data  <= chan_data[grant];
            out_ch    <= grant;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (load && advance_ptr) begin
            ptr <= ptr_next;
         end
      end
   end

`ifdef RR_STREAM_MUX_LOCK_EN
   // Packet lock: open on a non-last beat, close on the last beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_q   <= 1'b0;
         lock_ch  <= '0;
         out_last <= 1'b0;
      end else if (load) begin
         out_last <= last_pad[grant];
         lock_q   <= !last_pad[grant];
         lock_ch  <= grant;
      end
   end
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux (4-channel main instance plus a
// 5-channel instance for out-of-range fixed select). Table-driven cycles with
// a scoreboard of expected output beats; hand sequences for reset and lock.
module tb_rr_stream_mux;

   localparam int N_CH  = 4;
   localparam int W     = 8;
   localparam int SEL_W = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic                sel_mode;
   logic [SEL_W-1:0]    sel;
   logic [N_CH*W-1:0]   in_data;
   logic [N_CH-1:0]     in_valid;
   logic [N_CH-1:0]     in_ready;
   logic [W-1:0]        out_data;
   logic                out_valid;
   logic                out_ready;
   logic [SEL_W-1:0]    out_ch;

   logic                sel_mode5;
   logic [2:0]          sel5;
   logic [5*W-1:0]      in_data5;
   logic [4:0]          in_valid5;
   logic [4:0]          in_ready5;
   logic [W-1:0]        out_data5;
   logic                out_valid5;
   logic                out_ready5;
   logic [2:0]          out_ch5;

`ifdef RR_STREAM_MUX_LOCK_EN
   logic [N_CH-1:0]     in_last;
   logic                out_last;
   logic [4:0]          in_last5;
   logic                out_last5;
`endif

   rr_stream_mux #(.N_CH(N_CH), .W(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel_mode  (sel_mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef RR_STREAM_MUX_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch)
   );

   rr_stream_mux #(.N_CH(5), .W(W)) u_dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel_mode  (sel_mode5),
      .sel       (sel5),
      .in_data   (in_data5),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
`ifdef RR_STREAM_MUX_LOCK_EN
      .in_last   (in_last5),
      .out_last  (out_last5),
`endif
      .out_data  (out_data5),
      .out_valid (out_valid5),
      .out_ready (out_ready5),
      .out_ch    (out_ch5)
   );

   typedef struct {
      logic [W-1:0]     data;
      logic [SEL_W-1:0] ch;
      logic             last;
   } beat_t;

   typedef struct {
      string            name;
      logic [N_CH-1:0]  v;
      logic             rdy;
      logic             mode;
      logic [SEL_W-1:0] sel;
      logic [N_CH-1:0]  exp;
   } vec_t;

   beat_t      sb_q[$];
   vec_t       vecs[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       m_out_valid;
   logic [3:0] tag [N_CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input string name, input logic [N_CH-1:0] v, input logic rdy,
                               input logic mode, input logic [SEL_W-1:0] s,
                               input logic [N_CH-1:0] exp);
      vec_t t;
      t.name = name; t.v = v; t.rdy = rdy; t.mode = mode; t.sel = s; t.exp = exp;
      vecs.push_back(t);
   endfunction

   // Each channel carries {per-channel beat tag, channel id}; the tag only
   // advances when that channel's beat is accepted, so data is held while stalled.
   task automatic drive_data();
      for (int i = 0; i < N_CH; i++) begin
         in_data[i*W +: W] = {tag[i], 4'(i)};
      end
   endtask

   // One clock cycle: drive, check handshake and output against the
   // scoreboard, predict the next output state, then advance past the edge.
   task automatic cycle(input string name, input logic [N_CH-1:0] v, input logic rdy,
                        input logic mode, input logic [SEL_W-1:0] s,
                        input logic [N_CH-1:0] lst, input logic [N_CH-1:0] exp_rdy);
      beat_t b;
      in_valid = v; out_ready = rdy; sel_mode = mode; sel = s;
`ifdef RR_STREAM_MUX_LOCK_EN
      in_last = lst;
`endif
      drive_data();
      #1;
      check({name, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
      check({name, " out_valid"}, 32'(out_valid), 32'(m_out_valid));
      if (m_out_valid) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue required one beat", name);
         end else begin
            check({name, " out_data"}, 32'(out_data), 32'(sb_q[0].data));
            check({name, " out_ch"}, 32'(out_ch), 32'(sb_q[0].ch));
`ifdef RR_STREAM_MUX_LOCK_EN
            check({name, " out_last"}, 32'(out_last), 32'(sb_q[0].last));
`endif
            if (rdy) void'(sb_q.pop_front());
         end
      end
      if (exp_rdy != '0) begin
         b.ch = '0; b.data = '0; b.last = 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            if (exp_rdy[i]) begin
               b.ch   = SEL_W'(i);
               b.data = {tag[i], 4'(i)};
               b.last = lst[i];
               tag[i] = tag[i] + 4'd1;
            end
         end
         sb_q.push_back(b);
         m_out_valid = 1'b1;
      end else if (rdy) begin
         m_out_valid = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0; in_valid = '1; out_ready = 1'b1; sel_mode = 1'b0; sel = '0;
`ifdef RR_STREAM_MUX_LOCK_EN
      in_last = '1;
`endif
      for (int c = 0; c < cycles; c++) begin
         #1;
         check("reset in_ready", 32'(in_ready), 32'h0);
         @(posedge clk); #1;
      end
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset out_data", 32'(out_data), 32'h0);
      check("reset out_ch", 32'(out_ch), 32'h0);
      rst_n = 1'b1;
      sb_q.delete();
      m_out_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N_CH; i++) tag[i] = 4'd0;
      in_data = '0; m_out_valid = 1'b0;
      sel_mode5 = 1'b0; sel5 = '0; in_valid5 = '0; out_ready5 = 1'b1;
      for (int i = 0; i < 5; i++) in_data5[i*W +: W] = 8'hA0 + 8'(i);
`ifdef RR_STREAM_MUX_LOCK_EN
      in_last5 = '1;
`endif

      // Round-robin fairness with every channel valid.
      add("rr0", 4'b1111, 1, 0, 0, 4'b0001);
      add("rr1", 4'b1111, 1, 0, 0, 4'b0010);
      add("rr2", 4'b1111, 1, 0, 0, 4'b0100);
      add("rr3", 4'b1111, 1, 0, 0, 4'b1000);
      add("rr4", 4'b1111, 1, 0, 0, 4'b0001);
      add("rr5", 4'b1111, 1, 0, 0, 4'b0010);
      // Backpressure for five cycles, then release.
      for (int i = 0; i < 5; i++) add("bp", 4'b1111, 0, 0, 0, 4'b0000);
      add("bp_rel", 4'b1111, 1, 0, 0, 4'b0100);
      add("drain0", 4'b0000, 1, 0, 0, 4'b0000);
      add("drain1", 4'b0000, 1, 0, 0, 4'b0000);
      // Fixed select; the pointer must not move.
      add("fx_s2a", 4'b1111, 1, 1, 2, 4'b0100);
      add("fx_s2b", 4'b1111, 1, 1, 2, 4'b0100);
      add("fx_s2nv", 4'b1011, 1, 1, 2, 4'b0000);
      add("fx_s3", 4'b1111, 1, 1, 3, 4'b1000);
      add("rr_after_fx", 4'b1111, 1, 0, 0, 4'b1000);
      // Sparse round-robin: ptr reaches 2, then ch3 then ch1 (wrap).
      add("sp_set", 4'b0010, 1, 0, 0, 4'b0010);
      add("sp_ch3", 4'b1010, 1, 0, 0, 4'b1000);
      add("sp_ch1", 4'b1010, 1, 0, 0, 4'b0010);
      add("sp_ptr2", 4'b1111, 1, 0, 0, 4'b0100);
      add("drain2", 4'b0000, 1, 0, 0, 4'b0000);
      add("drain3", 4'b0000, 1, 0, 0, 4'b0000);
      // Empty slot accepts even with out_ready low; a full one does not.
      add("empty_nr", 4'b0001, 0, 0, 0, 4'b0001);
      add("full_nr", 4'b0001, 0, 0, 0, 4'b0000);
      add("drain4", 4'b0000, 1, 0, 0, 4'b0000);
      add("drain5", 4'b0000, 1, 0, 0, 4'b0000);

      do_reset(2);

      foreach (vecs[i]) begin
         cycle(vecs[i].name, vecs[i].v, vecs[i].rdy, vecs[i].mode, vecs[i].sel,
               4'b1111, vecs[i].exp);
      end

      // Reset mid-stream: pending beat discarded, pointer back to 0.
      cycle("mid_load", 4'b1111, 0, 0, 0, 4'b1111, 4'b0010);
      do_reset(1);
      cycle("post_rst", 4'b1111, 1, 0, 0, 4'b1111, 4'b0001);
      cycle("drain6", 4'b0000, 1, 0, 0, 4'b1111, 4'b0000);
      cycle("drain7", 4'b0000, 1, 0, 0, 4'b1111, 4'b0000);

`ifdef RR_STREAM_MUX_LOCK_EN
      // ch0 sends a 3-beat packet while ch1 stays valid; mode/sel are ignored
      // while locked.
      do_reset(1);
      cycle("lock0", 4'b0011, 1, 0, 0, 4'b1110, 4'b0001);
      cycle("lock1", 4'b0011, 1, 1, 1, 4'b1110, 4'b0001);
      cycle("lock2", 4'b0011, 1, 0, 0, 4'b1111, 4'b0001);
      cycle("lock3", 4'b0011, 1, 0, 0, 4'b1111, 4'b0010);
      cycle("drain8", 4'b0000, 1, 0, 0, 4'b1111, 4'b0000);
      cycle("drain9", 4'b0000, 1, 0, 0, 4'b1111, 4'b0000);
`endif

      check("sb_empty", 32'(sb_q.size()), 32'h0);

      // 5-channel instance: sel=7 accepts nothing, sel=4 accepts ch4.
      in_valid5 = '1; sel_mode5 = 1'b1; sel5 = 3'd7; out_ready5 = 1'b1;
      #1;
      check("n5 sel7 in_ready", 32'(in_ready5), 32'h0);
      @(posedge clk); #1;
      check("n5 sel7 out_valid", 32'(out_valid5), 32'h0);
      sel5 = 3'd4;
      #1;
      check("n5 sel4 in_ready", 32'(in_ready5), 32'h10);
      @(posedge clk); #1;
      in_valid5 = '0;
      check("n5 sel4 out_valid", 32'(out_valid5), 32'h1);
      check("n5 sel4 out_ch", 32'(out_ch5), 32'h4);
      check("n5 sel4 out_data", 32'(out_data5), 32'hA4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
